// File: rtl/cache_lookup_stage.sv
// Stage 2 of the 4-way, 16-set write-back data cache: tag compare, hit response,
// and the writeback/refill sequencer. Owns the per-set dirty bits and tree-PLRU state.
module cache_lookup_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  req_addr,
  input  logic [3:0]   req_rmask,
  input  logic [3:0]   req_wmask,
  input  logic [31:0]  req_wdata,
  input  logic         write_done_reg,
  input  logic [255:0] data_out [4],
  input  logic [23:0]  tag_out [4],
  input  logic         valid_out [4],
  input  logic         dfp_resp,
  output logic [31:0]  ufp_rdata,
  output logic         ufp_resp,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  output logic         dfp_write,
  output logic [255:0] dfp_wdata,
  output logic         read_halt,
  output logic         write_halt,
  output logic [1:0]   write_way,
  output logic         refill_valid,
  output logic [2:0]   lru_read
);

  localparam logic [1:0] COMPARE   = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;
  localparam logic [1:0] SETTLE    = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] victim_q, victim_d;
  logic [3:0] dirty_q [16];
  logic [2:0] lru_q [16];

  logic [3:0] set_idx;
  logic       req_valid;
  logic       hit;
  logic [1:0] hit_way;
  logic [1:0] victim_way;
  logic [2:0] lru_cur;
  logic [2:0] lru_hit;
  logic       lru_we;
  logic       dirty_set;
  logic       dirty_clr;

  // Store data is written by stage 1; tag bit 23 is not part of the compare.
  logic unused_ok;
  assign unused_ok = ^{req_wdata, tag_out[0][23], tag_out[1][23], tag_out[2][23],
                       tag_out[3][23], req_addr[1:0]};

  assign set_idx   = req_addr[8:5];
  assign req_valid = (|req_rmask) || (|req_wmask);
  assign lru_cur   = lru_q[set_idx];
  assign lru_read  = lru_cur;

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_out[i] && (tag_out[i][22:0] == req_addr[31:9])) begin
        hit     = 1'b1;
        hit_way = 2'(i);
      end
    end
  end

  always_comb begin
    if (lru_cur[0]) victim_way = lru_cur[1] ? 2'd0 : 2'd1;
    else            victim_way = lru_cur[2] ? 2'd2 : 2'd3;
  end

  // Point the tree away from the way just used; untouched bits are kept.
  always_comb begin
    lru_hit = lru_cur;
    unique case (hit_way)
      2'd0: lru_hit[1:0] = 2'b00;
      2'd1: lru_hit[1:0] = 2'b10;
      2'd2: begin lru_hit[2] = 1'b0; lru_hit[0] = 1'b1; end
      2'd3: begin lru_hit[2] = 1'b1; lru_hit[0] = 1'b1; end
      default: lru_hit = lru_cur;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    ufp_rdata    = 32'd0;
    ufp_resp     = 1'b0;
    dfp_addr     = 32'd0;
    dfp_read     = 1'b0;
    dfp_write    = 1'b0;
    dfp_wdata    = 256'd0;
    read_halt    = 1'b0;
    write_halt   = 1'b0;
    write_way    = 2'd0;
    refill_valid = 1'b0;
    lru_we       = 1'b0;
    dirty_set    = 1'b0;
    dirty_clr    = 1'b0;
    case (state_q)
      COMPARE: begin
        if (req_valid && !write_done_reg) begin
          if (hit) begin
            ufp_resp = 1'b1;
            lru_we   = 1'b1;
            if (|req_wmask) begin
              write_halt = 1'b1;
              write_way  = hit_way;
              dirty_set  = 1'b1;
            end else begin
              ufp_rdata = data_out[hit_way][{req_addr[4:2], 5'b0} +: 32];
            end
          end else begin
            read_halt = 1'b1;
            victim_d  = victim_way;
            if (valid_out[victim_way] && dirty_q[set_idx][victim_way]) state_d = WRITEBACK;
            else                                                        state_d = REFILL;
          end
        end
      end
      WRITEBACK: begin
        // Stage 1 is frozen, so the SRAM outputs for the victim stay stable.
        dfp_write = 1'b1;
        dfp_addr  = {tag_out[victim_q][22:0], set_idx, 5'b0};
        dfp_wdata = data_out[victim_q];
        read_halt = 1'b1;
        if (dfp_resp) begin
          dirty_clr = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        dfp_read  = 1'b1;
        dfp_addr  = {req_addr[31:5], 5'b0};
        read_halt = 1'b1;
        if (dfp_resp) begin
          refill_valid = 1'b1;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        read_halt = 1'b1;
        state_d   = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COMPARE;
      victim_q <= 2'd0;
      for (int s = 0; s < 16; s++) begin
        dirty_q[s] <= 4'd0;
        lru_q[s]   <= 3'd0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (lru_we)    lru_q[set_idx]             <= lru_hit;
      if (dirty_set) dirty_q[set_idx][hit_way]  <= 1'b1;
      if (dirty_clr) dirty_q[set_idx][victim_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_lookup_stage.sv
// Directed bench for cache_lookup_stage; the bench plays stage 1 and the SRAMs,
// presenting tag/data/valid vectors by hand and checking each cycle's outputs.
module tb_cache_lookup_stage;

  logic         clk;
  logic         rst;
  logic [31:0]  req_addr;
  logic [3:0]   req_rmask;
  logic [3:0]   req_wmask;
  logic [31:0]  req_wdata;
  logic         write_done_reg;
  logic [255:0] data_out [4];
  logic [23:0]  tag_out [4];
  logic         valid_out [4];
  logic         dfp_resp;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic         read_halt;
  logic         write_halt;
  logic [1:0]   write_way;
  logic         refill_valid;
  logic [2:0]   lru_read;

  int checks;
  int failures;

  cache_lookup_stage dut (
    .clk            (clk),
    .rst            (rst),
    .req_addr       (req_addr),
    .req_rmask      (req_rmask),
    .req_wmask      (req_wmask),
    .req_wdata      (req_wdata),
    .write_done_reg (write_done_reg),
    .data_out       (data_out),
    .tag_out        (tag_out),
    .valid_out      (valid_out),
    .dfp_resp       (dfp_resp),
    .ufp_rdata      (ufp_rdata),
    .ufp_resp       (ufp_resp),
    .dfp_addr       (dfp_addr),
    .dfp_read       (dfp_read),
    .dfp_write      (dfp_write),
    .dfp_wdata      (dfp_wdata),
    .read_halt      (read_halt),
    .write_halt     (write_halt),
    .write_way      (write_way),
    .refill_valid   (refill_valid),
    .lru_read       (lru_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  // Inputs change right after the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_way(input int w, input logic [23:0] tag, input logic [31:0] base);
    tag_out[w]   = tag;
    data_out[w]  = make_line(base);
    valid_out[w] = 1'b1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm);
    req_addr  = a;
    req_rmask = rm;
    req_wmask = wm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(32'h0, 4'h0, 4'h0);
    req_wdata      = 32'h0;
    write_done_reg = 1'b0;
    dfp_resp       = 1'b0;
    for (int w = 0; w < 4; w++) begin
      tag_out[w] = 24'h0; data_out[w] = 256'h0; valid_out[w] = 1'b0;
    end
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (ufp_resp !== 1'b0) begin failures++;
      $display("FAIL reset_ufp_resp got=%0h exp=0", ufp_resp); end
    checks++; if (read_halt !== 1'b0) begin failures++;
      $display("FAIL reset_read_halt got=%0h exp=0", read_halt); end
    checks++; if ({dfp_read, dfp_write} !== 2'b00) begin failures++;
      $display("FAIL reset_dfp_cmd got=%0h exp=0", {dfp_read, dfp_write}); end
    checks++; if (lru_read !== 3'b000) begin failures++;
      $display("FAIL reset_lru got=%0h exp=0", lru_read); end
  endtask

  task automatic test_clean_miss();
    step();
    set_req(32'h0000_0048, 4'hF, 4'h0);
    #1;
    checks++; if ({read_halt, ufp_resp, dfp_read} !== 3'b100) begin failures++;
      $display("FAIL miss_detect got=%0h exp=4", {read_halt, ufp_resp, dfp_read}); end
    step(); #1;
    checks++; if ({dfp_read, dfp_write, read_halt, refill_valid} !== 4'b1010) begin failures++;
      $display("FAIL refill_cmd got=%0h exp=a", {dfp_read, dfp_write, read_halt, refill_valid}); end
    checks++; if (dfp_addr !== 32'h0000_0040) begin failures++;
      $display("FAIL refill_addr got=%0h exp=40", dfp_addr); end
    step();
    dfp_resp = 1'b1;
    #1;
    checks++; if (refill_valid !== 1'b1) begin failures++;
      $display("FAIL refill_valid got=%0h exp=1", refill_valid); end
    step();
    dfp_resp = 1'b0;
    set_way(3, 24'h80_0000, 32'hA000_0000);
    #1;
    checks++; if ({read_halt, dfp_read, ufp_resp, refill_valid} !== 4'b1000) begin failures++;
      $display("FAIL settle got=%0h exp=8", {read_halt, dfp_read, ufp_resp, refill_valid}); end
    step(); #1;
    checks++; if ({ufp_resp, read_halt} !== 2'b10) begin failures++;
      $display("FAIL post_fill_resp got=%0h exp=2", {ufp_resp, read_halt}); end
    checks++; if (ufp_rdata !== 32'hA000_0002) begin failures++;
      $display("FAIL post_fill_rdata got=%0h exp=a0000002", ufp_rdata); end
  endtask

  task automatic test_read_hit();
    step();
    set_req(32'h0000_0044, 4'hF, 4'h0);
    #1;
    checks++; if (ufp_resp !== 1'b1) begin failures++;
      $display("FAIL hit_resp got=%0h exp=1", ufp_resp); end
    checks++; if (ufp_rdata !== 32'hA000_0001) begin failures++;
      $display("FAIL hit_rdata got=%0h exp=a0000001", ufp_rdata); end
    checks++; if (lru_read !== 3'b101) begin failures++;
      $display("FAIL hit_lru got=%0h exp=5", lru_read); end
  endtask

  task automatic test_write_hit();
    step();
    set_req(32'h0000_004C, 4'h0, 4'b0011);
    req_wdata = 32'h1234_5678;
    #1;
    checks++; if ({write_halt, ufp_resp, read_halt} !== 3'b110) begin failures++;
      $display("FAIL wr_hit got=%0h exp=6", {write_halt, ufp_resp, read_halt}); end
    checks++; if (write_way !== 2'd3) begin failures++;
      $display("FAIL wr_way got=%0h exp=3", write_way); end
    step();
    write_done_reg = 1'b1;
    #1;
    checks++; if ({write_halt, ufp_resp} !== 2'b00) begin failures++;
      $display("FAIL wr_bubble got=%0h exp=0", {write_halt, ufp_resp}); end
    step();
    write_done_reg = 1'b0;
    set_req(32'h0000_004C, 4'h0, 4'h0);
  endtask

  task automatic test_dirty_miss();
    set_way(0, 24'd1, 32'hB000_0000);
    set_way(1, 24'd2, 32'hC000_0000);
    set_way(2, 24'd3, 32'hD000_0000);
    set_req(32'h0000_0440, 4'hF, 4'h0);
    #1;
    checks++; if (ufp_rdata !== 32'hC000_0000) begin failures++;
      $display("FAIL way1_rdata got=%0h exp=c0000000", ufp_rdata); end
    step();
    set_req(32'h0000_065C, 4'hF, 4'h0);
    #1;
    checks++; if (lru_read !== 3'b110) begin failures++;
      $display("FAIL lru_after_w1 got=%0h exp=6", lru_read); end
    checks++; if (ufp_rdata !== 32'hD000_0007) begin failures++;
      $display("FAIL way2_rdata got=%0h exp=d0000007", ufp_rdata); end
    step();
    set_req(32'h0000_0250, 4'hF, 4'h0);
    #1;
    checks++; if (lru_read !== 3'b011) begin failures++;
      $display("FAIL lru_after_w2 got=%0h exp=3", lru_read); end
    checks++; if (ufp_rdata !== 32'hB000_0004) begin failures++;
      $display("FAIL way0_rdata got=%0h exp=b0000004", ufp_rdata); end
    step();
    set_req(32'h0000_0840, 4'hF, 4'h0);
    #1;
    checks++; if (lru_read !== 3'b000) begin failures++;
      $display("FAIL lru_after_w0 got=%0h exp=0", lru_read); end
    checks++; if ({read_halt, ufp_resp} !== 2'b10) begin failures++;
      $display("FAIL dmiss_detect got=%0h exp=2", {read_halt, ufp_resp}); end
    step(); #1;
    checks++; if ({dfp_write, dfp_read, read_halt} !== 3'b101) begin failures++;
      $display("FAIL wb_cmd got=%0h exp=5", {dfp_write, dfp_read, read_halt}); end
    checks++; if (dfp_addr !== 32'h0000_0040) begin failures++;
      $display("FAIL wb_addr got=%0h exp=40", dfp_addr); end
    checks++; if (dfp_wdata !== make_line(32'hA000_0000)) begin failures++;
      $display("FAIL wb_wdata got=%0h exp=line A", dfp_wdata); end
    step();
    dfp_resp = 1'b1;
    #1;
    checks++; if ({refill_valid, dfp_write} !== 2'b01) begin failures++;
      $display("FAIL wb_resp got=%0h exp=1", {refill_valid, dfp_write}); end
    step();
    dfp_resp = 1'b0;
    #1;
    checks++; if ({dfp_read, dfp_write} !== 2'b10) begin failures++;
      $display("FAIL d_refill_cmd got=%0h exp=2", {dfp_read, dfp_write}); end
    checks++; if (dfp_addr !== 32'h0000_0840) begin failures++;
      $display("FAIL d_refill_addr got=%0h exp=840", dfp_addr); end
    step();
    dfp_resp = 1'b1;
    #1;
    checks++; if (refill_valid !== 1'b1) begin failures++;
      $display("FAIL d_refill_valid got=%0h exp=1", refill_valid); end
    step();
    dfp_resp = 1'b0;
    set_way(3, 24'd4, 32'hE000_0000);
    step(); #1;
    checks++; if ({ufp_resp, ufp_rdata} !== {1'b1, 32'hE000_0000}) begin failures++;
      $display("FAIL d_post_fill got=%0h exp=1e0000000", {ufp_resp, ufp_rdata}); end
  endtask

  task automatic test_reset_mid_refill();
    step();
    set_req(32'h0000_0440, 4'h0, 4'hF);
    #1;
    checks++; if ({write_way, ufp_resp} !== 3'b011) begin failures++;
      $display("FAIL w1_write got=%0h exp=3", {write_way, ufp_resp}); end
    step();
    write_done_reg = 1'b1;
    step();
    write_done_reg = 1'b0;
    set_req(32'h0000_0A40, 4'hF, 4'h0);
    step(); #1;
    checks++; if ({dfp_read, dfp_write} !== 2'b10) begin failures++;
      $display("FAIL pre_rst_refill got=%0h exp=2", {dfp_read, dfp_write}); end
    checks++; if (lru_read !== 3'b110) begin failures++;
      $display("FAIL pre_rst_lru got=%0h exp=6", lru_read); end
    rst = 1'b1;
    set_req(32'h0000_0A40, 4'h0, 4'h0);
    step();
    rst = 1'b0;
    #1;
    checks++; if ({dfp_read, read_halt} !== 2'b00) begin failures++;
      $display("FAIL rst_mid_cmd got=%0h exp=0", {dfp_read, read_halt}); end
    checks++; if (lru_read !== 3'b000) begin failures++;
      $display("FAIL rst_mid_lru got=%0h exp=0", lru_read); end
    // Way1 was dirty before reset; after reset its eviction must skip writeback.
    step();
    set_req(32'h0000_0840, 4'hF, 4'h0);
    #1;
    checks++; if (ufp_resp !== 1'b1) begin failures++;
      $display("FAIL rst_hit got=%0h exp=1", ufp_resp); end
    step();
    set_req(32'h0000_0A40, 4'hF, 4'h0);
    #1;
    checks++; if (lru_read !== 3'b101) begin failures++;
      $display("FAIL rst_lru_hit got=%0h exp=5", lru_read); end
    step(); #1;
    checks++; if ({dfp_read, dfp_write} !== 2'b10) begin failures++;
      $display("FAIL dirty_cleared got=%0h exp=2", {dfp_read, dfp_write}); end
    step();
    dfp_resp = 1'b1;
    #1;
    checks++; if (refill_valid !== 1'b1) begin failures++;
      $display("FAIL final_refill got=%0h exp=1", refill_valid); end
    step();
    dfp_resp = 1'b0;
    set_req(32'h0, 4'h0, 4'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_reset_mid_refill();
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
